// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MDU_SIGNED_EN to enable signed MULT/DIV (op[0]); otherwise op[0] is ignored.
module mult_div_unit #(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] porta,
  input  logic [WORD_W-1:0] portb,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              dz
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_BUSY | cnt 0: load magnitudes (or divide-by-zero exit); cnt 1..WORD_W: one bit per cycle
  // S_DONE | hi/lo valid, done pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [WORD_W-1:0] a_q, b_q, m_q;
  logic [WORD_W-1:0] acc_hi, acc_lo;
  logic [WORD_W-1:0] hi_q, lo_q;
  logic              dz_q;

  logic              is_div, div_zero;
  logic [WORD_W-1:0] mag_a, mag_b;
  logic [WORD_W-1:0] step_hi, step_lo;
  logic [WORD_W-1:0] res_hi, res_lo;
  logic [WORD_W:0]   mul_sum, div_shift;
  logic [WORD_W-1:0] div_diff;
  logic              div_ge;

  assign is_div   = op_q[1];
  assign div_zero = is_div && (b_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_BUSY;
      S_BUSY: begin
        if (cnt_q == '0) begin
          if (div_zero) state_d = S_DONE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // multiply: acc_hi:acc_lo shifts right, multiplier bits leave through acc_lo[0]
  // divide:   acc_hi is the partial remainder, dividend bits shift out of acc_lo[MSB]
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
    div_shift = {acc_hi, acc_lo[WORD_W-1]};
    div_ge    = div_shift >= {1'b0, m_q};
    div_diff  = div_shift[WORD_W-1:0] - m_q;
    step_hi   = mul_sum[WORD_W:1];
    step_lo   = {mul_sum[0], acc_lo[WORD_W-1:1]};
    if (is_div) begin
      step_hi = div_ge ? div_diff : div_shift[WORD_W-1:0];
      step_lo = {acc_lo[WORD_W-2:0], div_ge};
    end
  end

`ifdef MDU_SIGNED_EN
  logic                neg_a, neg_b, neg_res;
  logic [2*WORD_W-1:0] prod, prod_fix;

  assign neg_a    = op_q[0] & a_q[WORD_W-1];
  assign neg_b    = op_q[0] & b_q[WORD_W-1];
  assign neg_res  = neg_a ^ neg_b;
  assign mag_a    = neg_a ? -a_q : a_q;
  assign mag_b    = neg_b ? -b_q : b_q;
  assign prod     = {step_hi, step_lo};
  assign prod_fix = neg_res ? -prod : prod;
  // remainder follows the dividend's sign, quotient/product follow the sign product
  assign res_hi   = is_div ? (neg_a   ? -step_hi : step_hi) : prod_fix[2*WORD_W-1:WORD_W];
  assign res_lo   = is_div ? (neg_res ? -step_lo : step_lo) : prod_fix[WORD_W-1:0];
`else
  logic unused_sign;

  assign unused_sign = op_q[0];
  assign mag_a       = a_q;
  assign mag_b       = b_q;
  assign res_hi      = step_hi;
  assign res_lo      = step_lo;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            a_q   <= porta;
            b_q   <= portb;
            dz_q  <= 1'b0;
            cnt_q <= '0;
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '0) begin
            if (div_zero) begin
              hi_q <= a_q;
              lo_q <= '1;
              dz_q <= 1'b1;
            end else begin
              acc_hi <= '0;
              acc_lo <= is_div ? mag_a : mag_b;
              m_q    <= is_div ? mag_b : mag_a;
            end
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt_q == LAST_CNT) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes reference results, monitor pops on done.
// Directed cases adapt to whether MDU_SIGNED_EN is defined.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         CLK, RST, start;
  logic [1:0]   op;
  logic [W-1:0] porta, portb;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WORD_W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op), .porta(porta), .portb(portb),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           busy_gap = 0;
  logic [W-1:0] last_hi = '0, last_lo = '0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural rules.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                                output logic rdz, output int lat);
    bit s;
    longint sa, sb_, q, r, p;
    longint unsigned up;
`ifdef MDU_SIGNED_EN
    s = o[0];
`else
    s = 1'b0;
`endif
    rdz = 1'b0;
    lat = W + 1;
    sa = $signed(a);
    sb_ = $signed(b);
    if (o[1]) begin
      if (b == '0) begin
        rhi = a; rlo = '1; rdz = 1'b1; lat = 1;
      end else if (s) begin
        q = sa / sb_; r = sa % sb_;
        rlo = q[W-1:0]; rhi = r[W-1:0];
      end else begin
        rlo = a / b; rhi = a % b;
      end
    end else if (s) begin
      p = sa * sb_;
      rhi = p[2*W-1:W]; rlo = p[W-1:0];
    end else begin
      up = 64'(a) * 64'(b);
      rhi = up[2*W-1:W]; rlo = up[W-1:0];
    end
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit junk, input bit fixed, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input logic edz);
    int n;
    int lat;
    exp_t e;
    n = 0;
    @(negedge CLK);
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(busy), 64'd0);
    check("hold_hi", 64'(hi), 64'(last_hi));
    check("hold_lo", 64'(lo), 64'(last_lo));
    start = 1'b1; op = o; porta = a; portb = b;
    model(o, a, b, e.hi, e.lo, e.dz, lat);
    if (fixed) begin
      e.hi = ehi; e.lo = elo; e.dz = edz;
    end
    e.cyc = cyc + 1 + lat;
    @(posedge CLK);
    sb.push_back(e);
    busy_gap = 0;
    if (junk) begin
      n = 0;
      while (n < 100) begin
        @(negedge CLK);
        if (done) break;
        start = 1'b1; op = 2'($urandom); porta = $urandom; portb = $urandom;
        n++;
      end
      start = 1'b0;
    end else begin
      @(negedge CLK);
      start = 1'b0;
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      if (sb.size() > 0 && !busy) busy_gap = 1;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("res_hi", 64'(hi), 64'(e.hi));
          check("res_lo", 64'(lo), 64'(e.lo));
          check("res_dz", 64'(dz), 64'(e.dz));
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("busy_high", 64'(busy_gap), 64'd0);
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: pick = '0;
      1: pick = '1;
      2: pick = 32'h8000_0000;
      3: pick = 32'd1;
      4: pick = 32'(($urandom_range(0, 15)));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int dcount;
    RST = 1'b1; start = 1'b1; op = 2'b00; porta = '1; portb = '1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(dz), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    RST = 1'b0; start = 1'b0;

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifdef MDU_SIGNED_EN
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(2'b10, 32'd100, 32'd7, 0, 1, 32'd2, 32'd14, 1'b0);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 32'h0, 32'h8000_0000, 1'b0);
`else
    issue(2'b01, 32'hFFFF_FFFF, 32'd2, 0, 1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0);
    issue(2'b10, 32'd100, 32'd7, 0, 1, 32'd2, 32'd14, 1'b0);
`endif

    // divide by zero, dz held in idle, cleared by next accept
    issue(2'b10, 32'd10, 32'd0, 0, 1, 32'd10, 32'hFFFF_FFFF, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    check("dz_hold", 64'(dz), 64'd1);
    issue(2'b00, 32'd3, 32'd4, 0, 1, 32'd0, 32'd12, 1'b0);
    check("dz_clear", 64'(dz), 64'd0);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 0, '0, '0, 1'b0);
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("drain", 64'(sb.size()), 64'd0);

    // abort by reset at BUSY cycle 10 with start held high
    issue(2'b00, $urandom, $urandom, 0, 0, '0, '0, 1'b0);
    void'(sb.pop_back());
    start = 1'b1;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    RST = 1'b0; start = 1'b0;
    last_hi = '0; last_lo = '0;
    dcount = 0;
    repeat (50) begin
      @(negedge CLK);
      if (done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);

    issue(2'b10, 32'd100, 32'd7, 0, 1, 32'd2, 32'd14, 1'b0);
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("final_drain", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
